// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: bias + sum(x*w) in Q6.9, handed to the sigmoid stage.
// Define NEURON_MAC_SAT_EN to clamp the result instead of wrapping it.
module neuron_mac #(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  input  logic [15:0] in_bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_z,
  output logic        out_sat
);

  localparam int CW = $clog2(N_INPUTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [15:0]             r_z, w_z_nxt;
  logic                    r_sat, w_sat_nxt;

  logic signed [31:0]      w_xs, w_ws, w_prod;
  logic signed [ACC_W-1:0] w_prod_x, w_bias_x;
  logic signed [ACC_W-1:0] w_base, w_sum, w_shift;
  logic [15:0]             w_zc;
  logic                    w_satc;
  logic                    w_beat, w_last;

  assign w_xs     = {{16{in_x[15]}}, in_x};
  assign w_ws     = {{16{in_w[15]}}, in_w};
  assign w_prod   = w_xs * w_ws;
  assign w_prod_x = ACC_W'(w_prod);
  assign w_bias_x = ACC_W'($signed(in_bias)) <<< 9;

  // The first beat seeds the sum with the bias instead of the stale acc.
  assign w_base  = (r_state == IDLE) ? w_bias_x : r_acc;
  assign w_sum   = w_base + w_prod_x;
  assign w_shift = w_sum >>> 9;

  assign in_ready  = (r_state != OUT);
  assign out_valid = (r_state == OUT);
  assign out_z     = r_z;
  assign out_sat   = r_sat;

  assign w_beat = in_valid && in_ready;
  assign w_last = (r_state == IDLE) ? (N_INPUTS == 1)
                                    : (r_cnt == CW'(N_INPUTS - 1));

`ifdef NEURON_MAC_SAT_EN
  logic w_ovf;
  assign w_ovf  = !((&w_shift[ACC_W-1:15]) || !(|w_shift[ACC_W-1:15]));
  assign w_zc   = w_ovf ? (w_shift[ACC_W-1] ? 16'h8000 : 16'h7FFF)
                        : w_shift[15:0];
  assign w_satc = w_ovf;
`else
  logic w_unused;
  assign w_unused = ^w_shift[ACC_W-1:16];
  assign w_zc     = w_shift[15:0];
  assign w_satc   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_z_nxt     = r_z;
    w_sat_nxt   = r_sat;
    if (in_clear) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE, ACC: begin
          if (w_beat) begin
            if (w_last) begin
              w_state_nxt = OUT;
              w_z_nxt     = w_zc;
              w_sat_nxt   = w_satc;
              w_acc_nxt   = '0;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ACC;
              w_acc_nxt   = w_sum;
              w_cnt_nxt   = r_cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_z     <= w_z_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

endmodule
